// File: rtl/train_pkg.sv
// rtl/train_pkg.sv - shared types and default sizes for the train step counter
package train_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_RISE,
    DB_HIGH,
    DB_FALL
  } db_state_t;

  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = 9;

endpackage

// File: rtl/train_step_counter_if.sv
// rtl/train_step_counter_if.sv - control/status bundle between controller FSM and step counter
interface train_step_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (output en, up, ld, ld_val, input count, tc, ovf);
  modport slave  (input en, up, ld, ld_val, output count, tc, ovf);

endinterface

// File: rtl/train_sensor_sync.sv
// rtl/train_sensor_sync.sv - sensor synchroniser, optional debounce (TRAIN_STEP_DEBOUNCE_EN), one step per rising edge
module train_sensor_sync
  import train_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor,
  output logic step
);

  logic       s1;
  logic       s2;
  logic [1:0] warm;
  logic       live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
    end
  end

  // Hold off edges until s2 reflects the real sensor, so a sensor already high at reset release is not counted.
  assign live = (warm == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= 2'd0;
    end else if (!live) begin
      warm <= warm + 2'd1;
    end
  end

`ifdef TRAIN_STEP_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_db_check
    $error("train_sensor_sync: DB_CYCLES must be at least 2");
  end

  db_state_t      state;
  logic [DBW-1:0] db_cnt;
  logic           step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DB_IDLE;
      db_cnt <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (!live) begin
        state  <= s2 ? DB_HIGH : DB_IDLE;
        db_cnt <= '0;
      end else begin
        case (state)
          DB_IDLE: if (s2) begin
            state  <= DB_RISE;
            db_cnt <= DBW'(1);
          end
          DB_RISE: if (!s2) begin
            state <= DB_IDLE;
          end else if (db_cnt == DB_LAST) begin
            state  <= DB_HIGH;
            step_q <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
          DB_HIGH: if (!s2) begin
            state  <= DB_FALL;
            db_cnt <= DBW'(1);
          end
          DB_FALL: if (s2) begin
            state <= DB_HIGH;
          end else if (db_cnt == DB_LAST) begin
            state <= DB_IDLE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
          default: state <= DB_IDLE;
        endcase
      end
    end
  end

  assign step = step_q;
`else
  if (DB_CYCLES < 1) begin : g_db_check
    $error("train_sensor_sync: DB_CYCLES must be positive");
  end

  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3 <= 1'b0;
    end else begin
      s3 <= s2;
    end
  end

  assign step = s2 & ~s3 & live;
`endif

endmodule

// File: rtl/train_step_counter.sv
// rtl/train_step_counter.sv - up/down track step counter with load, wrap/saturate and terminal count (debounce via TRAIN_STEP_DEBOUNCE_EN)
module train_step_counter
  import train_pkg::*;
#(
  parameter int WIDTH     = CNT_WIDTH,
  parameter int MAX_COUNT = CNT_MAX,
  parameter bit WRAP      = 1'b1,
  parameter int DB_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                sensor,
  train_step_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  if (MAX_COUNT > (1 << WIDTH) - 1) begin : g_max_check
    $error("train_step_counter: MAX_COUNT does not fit in WIDTH bits");
  end

  logic             step;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;

  train_sensor_sync #(
    .DB_CYCLES(DB_CYCLES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sensor(sensor),
    .step  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.ld) begin
        count_q <= (bus.ld_val > MAX_V) ? MAX_V : bus.ld_val;
        ovf_q   <= 1'b0;
      end else if (step && bus.en) begin
        if (bus.up) begin
          // >= also catches an out-of-range count and treats it as the limit.
          if (count_q >= MAX_V) begin
            tc_q <= 1'b1;
            if (WRAP) count_q <= '0;
            else      ovf_q   <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            tc_q <= 1'b1;
            if (WRAP) count_q <= MAX_V;
            else      ovf_q   <= 1'b1;
          end else if (count_q > MAX_V) begin
            count_q <= MAX_V;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_train_step_counter.sv
// tb/tb_train_step_counter.sv - self-checking bench for train_step_counter (wrap and saturate instances side by side)
module tb_train_step_counter;

  localparam int MAXC = 9;
  localparam int DB   = 4;
`ifdef TRAIN_STEP_DEBOUNCE_EN
  localparam int L = 2 + DB;
`else
  localparam int L = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sensor = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference state: index 0 is the wrapping counter, index 1 the saturating one.
  int mc[2];
  bit mo[2];

  train_step_counter_if #(.WIDTH(4)) bw ();
  train_step_counter_if #(.WIDTH(4)) bs ();

  train_step_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .WRAP(1'b1), .DB_CYCLES(DB)) dut_w (
    .clk(clk), .rst_n(rst_n), .sensor(sensor), .bus(bw)
  );
  train_step_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .WRAP(1'b0), .DB_CYCLES(DB)) dut_s (
    .clk(clk), .rst_n(rst_n), .sensor(sensor), .bus(bs)
  );

  always #5 clk = ~clk;

  function automatic int cnt(input int i);
    return (i == 0) ? int'(bw.count) : int'(bs.count);
  endfunction
  function automatic bit tcv(input int i);
    return (i == 0) ? bw.tc : bs.tc;
  endfunction
  function automatic bit ovv(input int i);
    return (i == 0) ? bw.ovf : bs.ovf;
  endfunction

  task automatic set_ctl(input bit en_v, input bit up_v, input bit ld_v, input logic [3:0] v);
    bw.en = en_v; bw.up = up_v; bw.ld = ld_v; bw.ld_val = v;
    bs.en = en_v; bs.up = up_v; bs.ld = ld_v; bs.ld_val = v;
  endtask

  task automatic model_step(input int i, input bit en_v, input bit up_v, output bit tc_v);
    tc_v = 1'b0;
    if (en_v) begin
      if (up_v) begin
        if (mc[i] >= MAXC) begin
          tc_v = 1'b1;
          if (i == 0) mc[i] = 0; else mo[i] = 1'b1;
        end else mc[i] = mc[i] + 1;
      end else begin
        if (mc[i] == 0) begin
          tc_v = 1'b1;
          if (i == 0) mc[i] = MAXC; else mo[i] = 1'b1;
        end else mc[i] = mc[i] - 1;
      end
    end
  endtask

  task automatic do_load(input int v);
    set_ctl(bw.en, bw.up, 1'b1, 4'(v));
    @(negedge clk);
    set_ctl(bw.en, bw.up, 1'b0, 4'(v));
    for (int i = 0; i < 2; i++) begin
      mc[i] = (v > MAXC) ? MAXC : v;
      mo[i] = 1'b0;
      checks++;
      if (cnt(i) !== mc[i] || ovv(i) !== 1'b0 || tcv(i) !== 1'b0) begin
        errors++;
        $display("FAIL load[%0d] v=%0d: count=%0d ovf=%0b tc=%0b, expected count=%0d ovf=0 tc=0",
                 i, v, cnt(i), ovv(i), tcv(i), mc[i]);
      end
    end
  endtask

  task automatic step_check(input string name, input bit en_v, input bit up_v);
    int old[2];
    bit etc[2];
    for (int i = 0; i < 2; i++) begin
      old[i] = mc[i];
      model_step(i, en_v, up_v, etc[i]);
    end
    set_ctl(en_v, up_v, 1'b0, 4'd0);
    sensor = 1'b1;
    repeat (L) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt(i) !== old[i]) begin
        errors++;
        $display("FAIL %s_early[%0d]: count=%0d, expected %0d", name, i, cnt(i), old[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt(i) !== mc[i] || tcv(i) !== etc[i] || ovv(i) !== mo[i]) begin
        errors++;
        $display("FAIL %s[%0d]: count=%0d tc=%0b ovf=%0b, expected count=%0d tc=%0b ovf=%0b",
                 name, i, cnt(i), tcv(i), ovv(i), mc[i], etc[i], mo[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (tcv(i) !== 1'b0 || cnt(i) !== mc[i]) begin
        errors++;
        $display("FAIL %s_after[%0d]: tc=%0b count=%0d, expected tc=0 count=%0d",
                 name, i, tcv(i), cnt(i), mc[i]);
      end
    end
    sensor = 1'b0;
    repeat (L + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; mo[i] = 1'b0;
      checks++;
      if (cnt(i) !== 0 || tcv(i) !== 1'b0 || ovv(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: count=%0d tc=%0b ovf=%0b, expected all 0", i, cnt(i), tcv(i), ovv(i));
      end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_count_up();
    for (int n = 0; n < 3; n++) step_check("count_up", 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    do_load(MAXC);
    step_check("wrap_up", 1'b1, 1'b1);
    step_check("wrap_down", 1'b1, 1'b0);
  endtask

  task automatic test_saturate();
    do_load(0);
    step_check("sat_down1", 1'b1, 1'b0);
    step_check("sat_down2", 1'b1, 1'b0);
    do_load(5);
  endtask

  task automatic test_load_priority();
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    sensor = 1'b1;
    repeat (L) @(negedge clk);
    set_ctl(1'b1, 1'b1, 1'b1, 4'd12);
    @(negedge clk);
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      mc[i] = MAXC; mo[i] = 1'b0;
      checks++;
      if (cnt(i) !== MAXC || tcv(i) !== 1'b0) begin
        errors++;
        $display("FAIL ld_clamp[%0d]: count=%0d tc=%0b, expected count=%0d tc=0", i, cnt(i), tcv(i), MAXC);
      end
    end
    sensor = 1'b0;
    repeat (L + 2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt(i) !== MAXC) begin
        errors++;
        $display("FAIL ld_step_lost[%0d]: count=%0d, expected %0d", i, cnt(i), MAXC);
      end
    end
  endtask

  task automatic test_enable();
    do_load(3);
    step_check("en_off1", 1'b0, 1'b1);
    step_check("en_off2", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 4) == 0) do_load(int'($urandom_range(0, 15)));
      else step_check("random", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_mid_reset();
    do_load(4);
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    sensor = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; mo[i] = 1'b0;
      checks++;
      if (cnt(i) !== 0 || tcv(i) !== 1'b0 || ovv(i) !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d]: count=%0d tc=%0b ovf=%0b, expected all 0", i, cnt(i), tcv(i), ovv(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt(i) !== 0) begin
        errors++;
        $display("FAIL held_sensor[%0d]: count=%0d, expected 0", i, cnt(i));
      end
    end
    sensor = 1'b0;
    repeat (L + 3) @(negedge clk);
    step_check("after_reset", 1'b1, 1'b1);
  endtask

`ifdef TRAIN_STEP_DEBOUNCE_EN
  task automatic pulse_and_check(input string name, input int hi1, input int lo, input int hi2, input int adds);
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    sensor = 1'b1;
    repeat (hi1) @(negedge clk);
    if (hi2 > 0) begin
      sensor = 1'b0;
      repeat (lo) @(negedge clk);
      sensor = 1'b1;
      repeat (hi2) @(negedge clk);
    end
    sensor = 1'b0;
    repeat (L + 6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mc[i] = mc[i] + adds;
      checks++;
      if (cnt(i) !== mc[i]) begin
        errors++;
        $display("FAIL %s[%0d]: count=%0d, expected %0d", name, i, cnt(i), mc[i]);
      end
    end
  endtask

  task automatic test_debounce();
    do_load(2);
    pulse_and_check("db_glitch", 2, 0, 0, 0);
    pulse_and_check("db_pulse6", 6, 0, 0, 1);
    pulse_and_check("db_dropout", 10, 1, 10, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate();
    test_load_priority();
    test_enable();
    test_random();
    test_mid_reset();
`ifdef TRAIN_STEP_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
